// File: rtl/pe_row_v2_block.sv
`default_nettype none
// ============================================================================
//  Module      : adder_v2
//  Description : Signed combinational adder, result wraps modulo 2^DATA_WIDTH.
//                No carry-out is produced.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_v2 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] in1,
  input  logic signed [DATA_WIDTH-1:0] in2,
  output logic signed [DATA_WIDTH-1:0] sum
);

  // Same-width add; the carry out of the top bit is discarded (wraps).
  assign sum = in1 + in2;

endmodule

// ============================================================================
//  Module      : pe_row_v2_block
//  Description : Row of NUM_PEs processing elements, each with NUM_MACS
//                signed multiplier lanes. Per lane, the enabled products of
//                all PEs are summed through a chain of adder_v2 instances and
//                added into a per-lane accumulator register that drives the
//                output directly. One cycle of latency from operands to
//                result; all arithmetic wraps at 2*DATA_WIDTH bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_row_v2_block #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PEs    = 4,
  parameter int NUM_MACS   = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rst_acc,
  input  logic [NUM_PEs-1:0]                        accumulate_en,
  input  logic [NUM_PEs*NUM_MACS*DATA_WIDTH-1:0]    a_flat,
  input  logic [NUM_PEs*NUM_MACS*DATA_WIDTH-1:0]    b_flat,
  output logic [NUM_MACS*2*DATA_WIDTH-1:0]          accumulated_results_flat
);

  // Width of products, partial sums and accumulators.
  localparam int ACC_W = 2 * DATA_WIDTH;

  // Gated product of each (PE, lane) pair; zero when the PE is disabled.
  logic signed [ACC_W-1:0] w_gated_prod [NUM_PEs][NUM_MACS];

  // Running cross-PE sum per lane: w_partial[m][p] = sum of PEs 0..p.
  logic signed [ACC_W-1:0] w_partial    [NUM_MACS][NUM_PEs];

  // Next accumulator value per lane (ACC + S).
  logic signed [ACC_W-1:0] w_acc_sum    [NUM_MACS];

  // Per-lane accumulator state.
  logic signed [ACC_W-1:0] r_acc        [NUM_MACS];

  // --------------------------------------------------------------------------
  // Multipliers: operands are sign-extended to the full product width first,
  // so the low ACC_W bits of the product are the exact signed result.
  // --------------------------------------------------------------------------
  generate
    for (genvar p = 0; p < NUM_PEs; p++) begin : g_pe
      for (genvar m = 0; m < NUM_MACS; m++) begin : g_mac
        logic signed [DATA_WIDTH-1:0] w_a;
        logic signed [DATA_WIDTH-1:0] w_b;
        logic signed [ACC_W-1:0]      w_a_ext;
        logic signed [ACC_W-1:0]      w_b_ext;
        logic signed [ACC_W-1:0]      w_prod;

        assign w_a     = a_flat[(p*NUM_MACS+m)*DATA_WIDTH +: DATA_WIDTH];
        assign w_b     = b_flat[(p*NUM_MACS+m)*DATA_WIDTH +: DATA_WIDTH];
        assign w_a_ext = {{DATA_WIDTH{w_a[DATA_WIDTH-1]}}, w_a};
        assign w_b_ext = {{DATA_WIDTH{w_b[DATA_WIDTH-1]}}, w_b};
        assign w_prod  = w_a_ext * w_b_ext;

        // A disabled PE contributes zero to every lane.
        assign w_gated_prod[p][m] = accumulate_en[p] ? w_prod : '0;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Cross-PE reduction per lane: a linear chain of adders seeded with PE 0.
  // --------------------------------------------------------------------------
  generate
    for (genvar m = 0; m < NUM_MACS; m++) begin : g_lane
      for (genvar p = 0; p < NUM_PEs; p++) begin : g_chain
        if (p == 0) begin : g_seed
          assign w_partial[m][p] = w_gated_prod[p][m];
        end else begin : g_add
          adder_v2 #(
            .DATA_WIDTH(ACC_W)
          ) u_pe_adder (
            .in1 (w_partial[m][p-1]),
            .in2 (w_gated_prod[p][m]),
            .sum (w_partial[m][p])
          );
        end
      end

      // Lane sum S(m) added to the current accumulator value.
      adder_v2 #(
        .DATA_WIDTH(ACC_W)
      ) u_acc_adder (
        .in1 (r_acc[m]),
        .in2 (w_partial[m][NUM_PEs-1]),
        .sum (w_acc_sum[m])
      );

      // Accumulator: async reset dominates, then sync clear, then accumulate.
      // With all enables low S is zero, so the register naturally holds.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_acc[m] <= '0;
        end else if (rst_acc) begin
          r_acc[m] <= '0;
        end else begin
          r_acc[m] <= w_acc_sum[m];
        end
      end

      // Output is taken straight from the accumulator register.
      assign accumulated_results_flat[m*ACC_W +: ACC_W] = r_acc[m];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pe_row_v2_block.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_row_v2_block
//  Description : Directed self-checking bench for pe_row_v2_block and a
//                standalone adder_v2 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_row_v2_block;

  localparam int DW   = 16;
  localparam int NPE  = 4;
  localparam int NMAC = 4;
  localparam int AW   = 2 * DW;

  logic                    clk;
  logic                    rst;
  logic                    rst_acc;
  logic [NPE-1:0]          accumulate_en;
  logic [NPE*NMAC*DW-1:0]  a_flat;
  logic [NPE*NMAC*DW-1:0]  b_flat;
  logic [NMAC*AW-1:0]      accumulated_results_flat;

  logic signed [31:0]      add_in1;
  logic signed [31:0]      add_in2;
  logic signed [31:0]      add_sum;

  int checks;
  int errors;

  pe_row_v2_block #(
    .DATA_WIDTH (DW),
    .NUM_PEs    (NPE),
    .NUM_MACS   (NMAC)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .rst_acc                  (rst_acc),
    .accumulate_en            (accumulate_en),
    .a_flat                   (a_flat),
    .b_flat                   (b_flat),
    .accumulated_results_flat (accumulated_results_flat)
  );

  adder_v2 #(
    .DATA_WIDTH (32)
  ) u_adder (
    .in1 (add_in1),
    .in2 (add_in2),
    .sum (add_sum)
  );

  // 10-time-unit clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Compare every lane against the same expected value.
  task automatic check_lanes(input string tag, input logic [31:0] exp);
    for (int m = 0; m < NMAC; m++) begin
      check_val($sformatf("%s lane%0d", tag, m),
                accumulated_results_flat[m*AW +: AW], exp);
    end
  endtask

  task automatic set_elem(input int p, input int m,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    a_flat[(p*NMAC+m)*DW +: DW] = a;
    b_flat[(p*NMAC+m)*DW +: DW] = b;
  endtask

  task automatic set_all(input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int p = 0; p < NPE; p++)
      for (int m = 0; m < NMAC; m++)
        set_elem(p, m, a, b);
  endtask

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    rst_acc       = 1'b0;
    accumulate_en = '0;
    a_flat        = '0;
    b_flat        = '0;
    add_in1       = '0;
    add_in2       = '0;

    // Reset state, with enables and operands active during reset.
    set_all(16'd1, 16'd1);
    accumulate_en = 4'hF;
    step();
    check_lanes("reset_state", 32'd0);

    // Release; ones everywhere, all PEs enabled: 4 then 8.
    rst = 1'b1;
    step();
    check_lanes("ones_edge1", 32'd4);
    step();
    check_lanes("ones_edge2", 32'd8);

    // Mid-run async reset: output clears without a clock edge.
    rst = 1'b0;
    #1;
    check_lanes("async_reset_now", 32'd0);
    rst_acc = 1'b0;
    step();
    check_lanes("reset_held", 32'd0);

    // Release: the first edge accumulates from zero.
    @(posedge clk);
    #1;
    check_lanes("reset_held_late", 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_lanes("after_release", 32'd4);

    // rst_acc clears then 2*3 with PEs 0,1 enabled -> 12.
    rst_acc = 1'b1;
    step();
    check_lanes("rst_acc_clear", 32'd0);
    rst_acc = 1'b0;
    set_all(16'd2, 16'd3);
    accumulate_en = 4'b0011;
    step();
    check_lanes("pe01_2x3", 32'd12);

    // All enables low: hold.
    accumulate_en = 4'b0000;
    step();
    check_lanes("hold", 32'd12);

    // Clear with all enables set: products discarded.
    accumulate_en = 4'hF;
    rst_acc = 1'b1;
    step();
    check_lanes("clear_discards", 32'd0);

    // Signed: PE0 -3 * 5 -> -15.
    rst_acc = 1'b0;
    set_all(16'd0, 16'd0);
    for (int m = 0; m < NMAC; m++) set_elem(0, m, 16'hFFFD, 16'd5);
    accumulate_en = 4'b0001;
    step();
    check_lanes("signed_neg15", 32'hFFFF_FFF1);

    // Wrap: (-2^15)^2 = 2^30, four of them wrap to 0.
    rst_acc = 1'b1;
    step();
    rst_acc = 1'b0;
    set_all(16'h8000, 16'h8000);
    accumulate_en = 4'hF;
    step();
    check_lanes("wrap_4x", 32'h0000_0000);

    // Three PEs: 3*2^30 = 0xC0000000; again -> 6*2^30 mod 2^32 = 0x80000000.
    accumulate_en = 4'b0111;
    step();
    check_lanes("wrap_3x", 32'hC000_0000);
    step();
    check_lanes("wrap_6x", 32'h8000_0000);

    // rst_acc with enables set -> 0.
    accumulate_en = 4'hF;
    rst_acc = 1'b1;
    step();
    check_lanes("wrap_clear", 32'd0);

    // Lane independence: lane m gets a=m+1, b=PE index+1.
    // Lane m sum = (m+1)*(1+2+3+4) = 10*(m+1).
    rst_acc = 1'b0;
    for (int p = 0; p < NPE; p++)
      for (int m = 0; m < NMAC; m++)
        set_elem(p, m, 16'(m + 1), 16'(p + 1));
    step();
    check_val("lane_indep lane0", accumulated_results_flat[0*AW +: AW], 32'd10);
    check_val("lane_indep lane1", accumulated_results_flat[1*AW +: AW], 32'd20);
    check_val("lane_indep lane2", accumulated_results_flat[2*AW +: AW], 32'd30);
    check_val("lane_indep lane3", accumulated_results_flat[3*AW +: AW], 32'd40);

    // Only PE2 enabled: adds 3*(m+1) -> 13, 26, 39, 52.
    accumulate_en = 4'b0100;
    step();
    check_val("pe2_only lane0", accumulated_results_flat[0*AW +: AW], 32'd13);
    check_val("pe2_only lane1", accumulated_results_flat[1*AW +: AW], 32'd26);
    check_val("pe2_only lane2", accumulated_results_flat[2*AW +: AW], 32'd39);
    check_val("pe2_only lane3", accumulated_results_flat[3*AW +: AW], 32'd52);

    // Standalone adder.
    add_in1 = 32'h7FFF_FFFF;
    add_in2 = 32'h0000_0001;
    #1;
    check_val("adder_overflow", add_sum, 32'h8000_0000);
    add_in1 = -32'sd5;
    add_in2 = 32'sd3;
    #1;
    check_val("adder_signed", add_sum, 32'hFFFF_FFFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
